// File: rtl/trace_collector.sv
// trace_collector: captures EX tracker records on each rising edge of
// ex_data_ready into a circular queue and serializes them as DATA_WIDTH
// words, least-significant word first, with a valid/ready handshake.
// The record type is carried as a flat TRACE_WIDTH-bit vector.
// Optional feature macro: TRACE_COLLECTOR_TIMESTAMP_EN. When it is defined,
// each record is preceded by one header word holding the counter value
// latched at capture.
module trace_collector #(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int TRACE_WIDTH = 72,
    parameter int NUM_WORDS   = (TRACE_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  counter,
    input  logic                         ex_data_ready,
    input  logic [TRACE_WIDTH-1:0]       ex_data_i,
    output logic [DATA_WIDTH-1:0]        trace_word_o,
    output logic                         trace_valid_o,
    output logic                         trace_last_o,
    input  logic                         trace_ready_i,
    output logic [15:0]                  dropped_count_o,
    output logic                         overflow_o,
    output logic [$clog2(QUEUE_DEPTH):0] queue_level_o
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PW = NUM_WORDS * DATA_WIDTH;

`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND_HDR = 2'd1, SEND_BODY = 2'd2} state_t;
    localparam state_t FIRST = SEND_HDR;
    logic [31:0] ts_mem [QUEUE_DEPTH];
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND_BODY = 2'd2} state_t;
    localparam state_t FIRST = SEND_BODY;
    logic unused_counter;
    assign unused_counter = ^counter;
`endif

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             edge_q;
    logic [15:0]      dropped_q, dropped_d;
    logic             overflow_q, overflow_d;

    logic [TRACE_WIDTH-1:0] data_mem [QUEUE_DEPTH];
    logic [PW-1:0]          padded;
    logic                   capture, full, push, pop, drop, is_last;

    // Next-state, handshake and queue bookkeeping; pop is resolved before push
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        trace_valid_o = 1'b0;
        trace_last_o  = 1'b0;
        trace_word_o  = '0;
        pop           = 1'b0;
        is_last       = (idx_q == IW'(NUM_WORDS - 1));
        padded        = '0;
        padded[TRACE_WIDTH-1:0] = data_mem[rd_ptr_q];
        capture       = ex_data_ready & ~edge_q;
        full          = (level_q == (AW+1)'(QUEUE_DEPTH));

        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    state_d = FIRST;
                    idx_d   = '0;
                end
            end
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
            SEND_HDR: begin
                trace_valid_o = 1'b1;
                trace_word_o  = DATA_WIDTH'(ts_mem[rd_ptr_q]);
                if (trace_ready_i) begin
                    state_d = SEND_BODY;
                    idx_d   = '0;
                end
            end
`endif
            SEND_BODY: begin
                trace_valid_o = 1'b1;
                trace_word_o  = padded[idx_q*DATA_WIDTH +: DATA_WIDTH];
                trace_last_o  = is_last;
                if (trace_ready_i) begin
                    if (is_last) pop = 1'b1;
                    else         idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        push = capture & (~full | pop);
        drop = capture & full & ~pop;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);

        // Chain straight into the next record (including one pushed this cycle)
        if (pop) begin
            state_d = (level_d != '0) ? FIRST : IDLE;
            idx_d   = '0;
        end

        dropped_d  = (drop && dropped_q != 16'hFFFF) ? dropped_q + 16'd1 : dropped_q;
        overflow_d = overflow_q | drop;

        dropped_count_o = dropped_q;
        overflow_o      = overflow_q;
        queue_level_o   = level_q;
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            edge_q     <= 1'b0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            edge_q     <= ex_data_ready;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    // Record storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= ex_data_i;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
            ts_mem[wr_ptr_q]   <= counter;
`endif
        end
    end

endmodule

// File: doc/trace_collector.md
TRACE_COLLECTOR -- requirements
Module: trace_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each output trace word.
REQ-002 Parameter QUEUE_DEPTH, default 4, number of trace records buffered; power of two, 2..16.
REQ-003 Parameter NUM_WORDS, default ceil($bits(trace_output)/DATA_WIDTH), number of body words per record.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 counter  in  integer  free-running cycle counter, shared with the pipeline trackers.
REQ-007 ex_data_ready  in  1  EX tracker record-available flag; may stay high across several cycles.
REQ-008 ex_data_i  in  trace_output  EX tracker record; stable while ex_data_ready is high.
REQ-009 trace_word_o  out  DATA_WIDTH  current serialized trace word.
REQ-010 trace_valid_o  out  1  trace_word_o is valid.
REQ-011 trace_last_o  out  1  current word is the final word of a record.
REQ-012 trace_ready_i  in  1  downstream accepts the word when high in the same cycle as trace_valid_o.
REQ-013 dropped_count_o  out  16  records lost to overflow, saturating at 16'hFFFF.
REQ-014 overflow_o  out  1  sticky; set on the first dropped record.
REQ-015 queue_level_o  out  $clog2(QUEUE_DEPTH)+1  records currently held, including the one being sent.

Function
REQ-016 Capture SHALL occur on each clk edge where ex_data_ready is 1 and its registered previous value is 0; one record per rising edge of ex_data_ready.
REQ-017 The captured record SHALL be written into a circular queue; read and write pointers wrap modulo QUEUE_DEPTH.
REQ-018 When the queue is full at capture, the record SHALL be discarded, dropped_count_o SHALL increment (saturating) and overflow_o SHALL set.
REQ-019 FSM states SHALL be IDLE, SEND_HDR and SEND_BODY; IDLE->SEND_HDR (or ->SEND_BODY when the header is not compiled in) when the queue is non-empty.
REQ-020 SEND_BODY SHALL emit the head record as NUM_WORDS words, least-significant word first, with the final word zero-padded above the record width.
REQ-021 The word index SHALL advance only on a cycle where trace_valid_o and trace_ready_i are both 1; trace_word_o SHALL hold stable while trace_ready_i is 0.
REQ-022 trace_last_o SHALL be 1 only on body word NUM_WORDS-1.
REQ-023 On acceptance of the last word, the head slot SHALL be freed; next state SHALL be SEND_HDR or SEND_BODY if another record is queued (no idle bubble), else IDLE.
REQ-024 A capture in the same cycle as a last-word acceptance with the queue full SHALL be stored: pop before push, no drop.
REQ-025 Latency: a record captured into an empty queue at edge N SHALL present its first word with trace_valid_o=1 after edge N+1.
REQ-026 trace_valid_o SHALL be 0 in IDLE.

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, pointers 0, queue_level_o 0, trace_valid_o 0, trace_last_o 0, trace_word_o 0, dropped_count_o 0, overflow_o 0, edge-detect register 0.
REQ-028 Reset during a transfer SHALL abandon the partial record without completing it; no word is re-emitted after reset.

Configuration
REQ-029 Macro TRACE_COLLECTOR_TIMESTAMP_EN, when defined, SHALL latch counter at capture and emit it as one header word (SEND_HDR, trace_last_o=0) before each record body.
REQ-030 Without TRACE_COLLECTOR_TIMESTAMP_EN, SEND_HDR and the timestamp storage SHALL be absent and each record SHALL consist of NUM_WORDS words.

Verification
REQ-031 Single record, trace_ready_i held 1, macro off -> NUM_WORDS consecutive valid words, LSW first, trace_last_o on the final word, then IDLE.
REQ-032 trace_ready_i toggled 1,0,0,1 during transfer -> word held over the 0 cycles, no word skipped or duplicated.
REQ-033 Five rising edges of ex_data_ready with trace_ready_i=0, QUEUE_DEPTH=4 -> queue_level_o=4, dropped_count_o=1, overflow_o=1.
REQ-034 Full queue, capture coincident with last-word accept -> record stored, dropped_count_o unchanged, queue_level_o stays 4.
REQ-035 Macro on, capture at counter=100 -> first word 32'd100 with trace_last_o=0, followed by the NUM_WORDS body words.
REQ-036 rst pulsed mid-record -> trace_valid_o falls asynchronously, all counters 0, next capture is emitted from word 0.
